// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO register pair.
// One shared 2*XLEN shift/accumulate register, one bit per cycle.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            hilo_rd,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t            state, state_n;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   bop;
  logic [CW-1:0]     cnt;
  logic              sign_q, sign_r, is_div, dz;

  logic              sa, sb, is_md, rt_zero;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, prod_fix;
  logic [XLEN-1:0]   q_fix, r_fix;

  assign busy    = (state != IDLE);
  assign stall   = busy & (start | hilo_rd);
  assign is_md   = start & ~op[2];
  assign rt_zero = (rt_val == '0);

  assign sa    = ~op[0] & rs_val[XLEN-1];
  assign sb    = ~op[0] & rt_val[XLEN-1];
  assign abs_a = sa ? -rs_val : rs_val;
  assign abs_b = sb ? -rt_val : rt_val;

  // MUL: multiplier sits in the low half and shifts out as partial sums shift in
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]}
                 + (acc[0] ? {1'b0, bop} : '0);
  assign mul_nxt = {mul_sum, acc[XLEN-1:1]};

  // DIV: remainder in the high half, dividend/quotient in the low half
  assign div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, bop};
  assign div_nxt   = div_trial[XLEN]
                   ? {acc[2*XLEN-2:0], 1'b0}
                   : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  assign prod_fix = sign_q ? -acc : acc;
  assign q_fix    = sign_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign r_fix    = sign_r ? -acc[2*XLEN-1:XLEN]
                           : acc[2*XLEN-1:XLEN];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (is_md) begin
          if (op[1] && rt_zero) state_n = FIX;
          else if (op[1])       state_n = DIV;
          else                  state_n = MUL;
        end
      end
      MUL, DIV: begin
        if (cnt == CW'(XLEN-1)) state_n = FIX;
      end
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      acc    <= '0;
      bop    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      is_div <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!flush) begin
        unique case (state)
          IDLE: begin
            if (start) begin
              unique case (op)
                3'd4: hi <= rs_val;
                3'd5: lo <= rs_val;
                3'd0, 3'd1, 3'd2, 3'd3: begin
                  cnt    <= '0;
                  is_div <= op[1];
                  dz     <= op[1] & rt_zero;
                  sign_q <= sa ^ sb;
                  sign_r <= sa;
                  bop    <= op[1] ? abs_b : abs_a;
                  if (op[1] && rt_zero)
                    acc <= {rs_val, {XLEN{1'b1}}};
                  else
                    acc <= {{XLEN{1'b0}}, op[1] ? abs_a : abs_b};
                end
                default: ;
              endcase
            end
          end
          MUL: begin
            acc <= mul_nxt;
            cnt <= cnt + CW'(1);
          end
          DIV: begin
            acc <= div_nxt;
            cnt <= cnt + CW'(1);
          end
          FIX: begin
            done <= 1'b1;
            if (dz) begin
              hi <= acc[2*XLEN-1:XLEN];
              lo <= acc[XLEN-1:0];
            end else if (is_div) begin
              hi <= r_fix;
              lo <= q_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq with a plain-arithmetic reference model.
module tb_muldiv_seq;

  logic        clk = 0;
  logic        reset, start, hilo_rd, flush;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [63:0] expq[$];

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .hilo_rd(hilo_rd),
    .flush(flush), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    if (o[1] && b == 0) return {a, 32'hFFFF_FFFF};
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return 64'(ua * ub);
      3'd2: begin q = sa / sb; r = sa % sb; end
      default: begin q = ua / ub; r = ua % ub; end
    endcase
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 expected no result");
      end else begin
        chk("result", {hi, lo}, expq.pop_front());
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit push);
    start = 1; op = o; rs_val = a; rt_val = b;
    if (push) expq.push_back(model(o, a, b));
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  int n;
  logic [2:0]  ro;
  logic [31:0] ra, rb;

  initial begin
    reset = 1; start = 0; hilo_rd = 0; flush = 0;
    op = 0; rs_val = 0; rt_val = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("reset_hilo", {hi, lo}, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    wait_idle(n);
    chk("multu_busy_len", 64'(n), 64'd33);
    chk("multu_done", {63'h0, done}, 64'h1);
    @(posedge clk); #1;
    chk("done_one_cycle", {63'h0, done}, 64'h0);

    issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1);
    start = 1; op = 3'd1; rs_val = 2; rt_val = 3;
    #1;
    n = 0;
    while (stall && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_stall_len", 64'(n), 64'd33);
    expq.push_back(model(3'd1, 32'd2, 32'd3));
    @(posedge clk); #1;
    start = 0;
    wait_idle(n);
    chk("b2b_busy_len", 64'(n), 64'd33);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1);
    wait_idle(n);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_idle(n);
    issue(3'd3, 32'd5, 32'd0, 1);
    wait_idle(n);
    chk("divzero_busy_len", 64'(n), 64'd1);
    @(posedge clk); #1;

    issue(3'd4, 32'h1234, 32'h0, 0);
    chk("mthi", {32'h0, hi}, 64'h1234);
    chk("mthi_busy", {63'h0, busy}, 64'h0);
    issue(3'd5, 32'h5678, 32'h0, 0);
    chk("mtlo", {hi, lo}, {32'h1234, 32'h5678});

    start = 1; op = 3'd4; rs_val = 32'hDEAD; flush = 1;
    @(posedge clk); #1;
    start = 0; flush = 0;
    chk("flush_beats_mthi", {32'h0, hi}, 64'h1234);

    issue(3'd0, 32'h55, 32'h77, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_idle", {63'h0, busy}, 64'h0);
    chk("flush_hilo", {hi, lo}, {32'h1234, 32'h5678});
    repeat (40) @(posedge clk);
    #1;
    chk("flush_hilo_late", {hi, lo}, {32'h1234, 32'h5678});

    issue(3'd2, 32'd1000, 32'd7, 0);
    repeat (5) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("reset_mid_hilo", {hi, lo}, 64'h0);
    chk("reset_mid_busy", {63'h0, busy}, 64'h0);

    hilo_rd = 1;
    #1;
    chk("idle_stall", {63'h0, stall}, 64'h0);
    issue(3'd0, 32'd12345, 32'hFFFF_0000, 1);
    n = 0;
    while (stall && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hilo_rd_stall_len", 64'(n), 64'd33);
    chk("hilo_rd_done", {63'h0, done}, 64'h1);
    hilo_rd = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      issue(ro, ra, rb, 1);
      wait_idle(n);
      if (n >= 100) chk("timeout", 64'(n), 64'd33);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO issued from the decode stage alongside the ALU.
- Produces a stall request that freezes the front of the pipeline while an operation is in flight and a dependent instruction is waiting.
- Uses one shared 64-bit shift/accumulate datapath, one bit per cycle.

Parameters:
XLEN, 32, operand width; HI/LO are XLEN each; iteration count = XLEN.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  issue strobe; sampled each rising edge
op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
rs_val  in  XLEN  operand A (multiplicand/dividend/MTxx source)
rt_val  in  XLEN  operand B (multiplier/divisor)
hilo_rd  in  1  an MFHI/MFLO is in decode this cycle
flush  in  1  exception/flush; aborts any in-flight operation
busy  out  1  high when state != IDLE
stall  out  1  busy & (start | hilo_rd), combinational
done  out  1  one-cycle pulse when HI/LO are written by a mul/div
hi  out  XLEN  HI register, registered
lo  out  XLEN  LO register, registered

Behaviour:
- Reset: state IDLE, hi=0, lo=0, done=0, busy=0, iteration counter=0. Reset mid-operation aborts the operation and clears HI/LO.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start with op 0-3:
  - Latch |A| and |B|; signed ops take magnitudes, unsigned ops take raw values.
  - Latch sign_q = signA^signB and sign_r = signA, both forced to 0 for unsigned ops.
  - Clear counter; go to MUL (op 0/1) or DIV (op 2/3).
- IDLE, start with op 4/5: write hi (op 4) or lo (op 5) = rs_val at that edge; stay IDLE; no done, no busy.
- IDLE, start with op 6/7: ignored.
- MUL: one shift-add step per edge on the 64-bit product register. After XLEN steps (counter == XLEN-1), go to FIX.
- DIV: one restoring step per edge (shift remainder, trial-subtract, set quotient bit). After XLEN steps, go to FIX.
- FIX:
  - MUL: {hi,lo} = sign_q ? -product : product.
  - DIV: lo = sign_q ? -quotient : quotient; hi = sign_r ? -remainder : remainder.
  - Set done=1 for one cycle; go to IDLE.
- Latency: start sampled at edge E0, steps at E1..E32, FIX at E33. New HI/LO and done are visible in the cycle after E33. busy is high for 33 cycles.
- Divide by zero (DIV/DIVU, rt_val==0): skip DIV and go straight to FIX. FIX writes lo=all-ones, hi=rs_val (raw, unnegated) and pulses done. busy is high for 1 cycle.
- DIV 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 through the normal path; no trap.
- start while busy: ignored. The issuer is held by stall and re-presents start. Because state is IDLE after E33, the re-presented start is accepted in the done cycle.
- hilo_rd while busy: stall=1. It deasserts in the done cycle, so MFHI reads the new values.
- flush: from any state, go to IDLE at the next edge.
  - HI/LO are unchanged and no done pulse is produced.
  - flush has priority over a start in the same cycle, including MTHI/MTLO.
- hi/lo change only at reset, MTHI/MTLO, or in FIX.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF → busy 33 cycles, then done pulses 1 cycle with hi=0xFFFFFFFE, lo=0x00000001.
- MULT rs=0xFFFFFFFD (-3) rt=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Follow with back-to-back MULTU 2×3 held by stall → accepted in done cycle; lo=6 33 cycles later.
- DIV rs=0xFFFFFFF9 (-7) rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV rs=0x80000000 rt=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU rs=5 rt=0 → busy 1 cycle, then done with lo=0xFFFFFFFF, hi=5.
- MTHI 0x1234, then MTLO 0x5678 (hi/lo update next edge, no done). Start MULT, assert flush at step 10 → IDLE next edge, hi=0x1234, lo=0x5678, no done. Assert reset during a DIV → hi=lo=0, busy=0.
- hilo_rd held during MULT → stall=1 for exactly the 33 busy cycles, 0 in the done cycle. hilo_rd in IDLE → stall=0.
